tqv_peri_fabric: RTL and testbench

Parametrised peripheral interconnect for the TinyQV core, sitting between the core's peripheral data port and NUM_FULL full-interface slots plus NUM_BYTE byte-interface slots. It decodes addresses, gates per-slot read/write strobes, and registers read data behind a response state machine with a stall timeout. Slot 0 is an internal control block: interrupt enable mask, raw interrupt status, and timeout diagnostics. It generalises the fixed 12+8 wrapper to configurable slot counts, multi-cycle peripheral reads, timeout recovery and interrupt masking.

---
 rtl/tqv_peri_fabric.sv | 268 ++++++++++++++++++++++++++
 tb/tb_tqv_peri_fabric.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_peri_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : tqv_peri_fabric
//  Purpose  : Peripheral interconnect for the TinyQV core. Decodes the core's
//             peripheral address into NUM_FULL full-interface slots and
//             NUM_BYTE byte-interface slots, gates per-slot strobes, and
//             returns registered read data through an IDLE/WAIT/HOLD response
//             machine with a stall timeout. Full slot 0 is an internal
//             control block (IRQ enable, raw IRQ status, timeout diagnostics).
//
//  Ports    : clk, rst_n            - clock, synchronous active-low reset
//             addr_in[10:0]         - peripheral byte address
//             data_in[31:0]         - write data
//             data_write_n[1:0]     - 11 none, 00 byte, 01 half, 10 word
//             data_read_n[1:0]      - same encoding for reads
//             data_read_complete    - core has consumed the read data
//             data_out[31:0]        - registered read data
//             data_ready            - read data valid / write accepted
//             slot_write_n, slot_read_n - 2 bits per full slot, 11 = idle
//             slot_data, slot_ready - per full slot read data / ready
//             byte_write            - per byte slot write pulse
//             byte_data             - per byte slot read data (always ready)
//             slot_irq, irq_out     - raw and masked/registered interrupts
//
//  Revision : 1.0 - initial release
// ============================================================================
module tqv_peri_fabric #(
    parameter int          NUM_FULL       = 12,
    parameter int          NUM_BYTE       = 8,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [10:0]             addr_in,
    input  logic [31:0]             data_in,
    input  logic [1:0]              data_write_n,
    input  logic [1:0]              data_read_n,
    input  logic                    data_read_complete,
    output logic [31:0]             data_out,
    output logic                    data_ready,
    output logic [2*NUM_FULL-1:0]   slot_write_n,
    output logic [2*NUM_FULL-1:0]   slot_read_n,
    input  logic [32*NUM_FULL-1:0]  slot_data,
    input  logic [NUM_FULL-1:0]     slot_ready,
    output logic [NUM_BYTE-1:0]     byte_write,
    input  logic [8*NUM_BYTE-1:0]   byte_data,
    input  logic [NUM_FULL-1:0]     slot_irq,
    output logic [NUM_FULL-1:0]     irq_out
);

    // Counter wide enough to hold TIMEOUT_CYCLES itself.
    localparam int                 CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(TIMEOUT_CYCLES);
    localparam logic               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    // Slot 0 has no external interrupt; its bit is forced low everywhere.
    localparam logic [NUM_FULL-1:0] IRQ_MASK  = {{(NUM_FULL-1){1'b1}}, 1'b0};

    localparam logic [5:0] OFS_IRQ_EN     = 6'h00;
    localparam logic [5:0] OFS_IRQ_STATUS = 6'h04;
    localparam logic [5:0] OFS_TIMEOUT    = 6'h08;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          data_q, data_d;
    logic                 ready_q, ready_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 to_set;
    logic [NUM_FULL-1:0]  irq_en_q;
    logic                 to_flag_q;
    logic [3:0]           to_slot_q;
    logic [NUM_FULL-1:0]  irq_out_q;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic       is_byte;
    logic [3:0] full_idx;
    logic [2:0] byte_idx;
    logic       full_hit, byte_hit, ctrl_hit, ext_hit;
    logic       rd_req, wr_req;

    assign is_byte  = (addr_in[10:9] == 2'b10);
    assign full_idx = addr_in[9:6];
    assign byte_idx = addr_in[6:4];
    assign full_hit = !is_byte && (32'(full_idx) < NUM_FULL);
    assign byte_hit = is_byte && (32'(byte_idx) < NUM_BYTE);
    assign ctrl_hit = full_hit && (full_idx == 4'd0);
    assign ext_hit  = full_hit && (full_idx != 4'd0);
    assign rd_req   = (data_read_n != 2'b11);
    assign wr_req   = (data_write_n != 2'b11);

    // ------------------------------------------------------------------
    // Strobe fan-out. Slot 0 is serviced internally, so its lane stays idle.
    // Read strobes follow the live request in IDLE and WAIT and are held
    // off in HOLD so the peripheral does not see a second read.
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_FULL; i++) begin : g_full
            if (i == 0) begin : g_ctrl
                assign slot_write_n[1:0] = 2'b11;
                assign slot_read_n[1:0]  = 2'b11;
            end else begin : g_ext
                logic sel;
                assign sel = ext_hit && (full_idx == 4'(i));
                assign slot_write_n[2*i +: 2] = sel ? data_write_n : 2'b11;
                assign slot_read_n[2*i +: 2]  = (sel && (state_q != S_HOLD)) ? data_read_n : 2'b11;
            end
        end
        for (genvar i = 0; i < NUM_BYTE; i++) begin : g_byte
            assign byte_write[i] = wr_req && byte_hit && (byte_idx == 3'(i));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read source mux
    // ------------------------------------------------------------------
    logic [31:0] ext_data;
    logic        ext_ready;
    logic [7:0]  byte_val;
    logic [31:0] ctrl_data;
    logic [31:0] rd_data;
    logic        src_ready;

    always_comb begin
        ext_data  = '0;
        ext_ready = 1'b0;
        for (int i = 1; i < NUM_FULL; i++) begin
            if (full_idx == 4'(i)) begin
                ext_data  = slot_data[32*i +: 32];
                ext_ready = slot_ready[i];
            end
        end
    end

    always_comb begin
        byte_val = '0;
        for (int i = 0; i < NUM_BYTE; i++) begin
            if (byte_idx == 3'(i)) begin
                byte_val = byte_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        ctrl_data = '0;
        case (addr_in[5:0])
            OFS_IRQ_EN:     ctrl_data[NUM_FULL-1:0] = irq_en_q;
            OFS_IRQ_STATUS: ctrl_data[NUM_FULL-1:0] = slot_irq & IRQ_MASK;
            OFS_TIMEOUT:    ctrl_data[7:0]          = {to_slot_q, 3'b000, to_flag_q};
            default:        ctrl_data               = '0;
        endcase
    end

    // Unmapped addresses (including out-of-range byte slots) read as zero
    // and are always ready so the core never stalls on a bad address.
    always_comb begin
        rd_data   = '0;
        src_ready = 1'b1;
        if (byte_hit) begin
            rd_data = {24'd0, byte_val};
        end else if (ctrl_hit) begin
            rd_data = ctrl_data;
        end else if (ext_hit) begin
            rd_data   = ext_data;
            src_ready = ext_ready;
        end
    end

    // ------------------------------------------------------------------
    // Read response machine
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ready_d = 1'b0;
        cnt_d   = cnt_q;
        to_set  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    if (src_ready) begin
                        data_d  = rd_data;
                        ready_d = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // Abort beats ready, ready beats timeout on the same cycle.
                if (!rd_req) begin
                    state_d = S_IDLE;
                end else if (src_ready) begin
                    data_d  = rd_data;
                    ready_d = 1'b1;
                    state_d = S_HOLD;
                end else if (TIMEOUT_EN && (cnt_q == CNT_MAX)) begin
                    data_d  = ERR_DATA;
                    ready_d = 1'b1;
                    to_set  = 1'b1;
                    state_d = S_HOLD;
                end else if (TIMEOUT_EN) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (data_read_complete) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Control block registers and interrupt masking
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            irq_en_q  <= '0;
            to_flag_q <= 1'b0;
            to_slot_q <= '0;
            irq_out_q <= '0;
        end else begin
            if (wr_req && ctrl_hit && (addr_in[5:0] == OFS_IRQ_EN)) begin
                irq_en_q <= data_in[NUM_FULL-1:0] & IRQ_MASK;
            end
            if (wr_req && ctrl_hit && (addr_in[5:0] == OFS_TIMEOUT) && data_in[0]) begin
                to_flag_q <= 1'b0;
                to_slot_q <= '0;
            end
            // Placed after the clear so a fresh timeout overrides it.
            if (to_set) begin
                to_flag_q <= 1'b1;
                to_slot_q <= full_idx;
            end
            irq_out_q <= slot_irq & irq_en_q;
        end
    end

    assign data_out   = data_q;
    assign data_ready = ready_q | wr_req;
    assign irq_out    = irq_out_q;

endmodule
`default_nettype wire

// File: tb/tb_tqv_peri_fabric.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tqv_peri_fabric
//  Purpose  : Self-checking bench for tqv_peri_fabric. A default-sized
//             instance exercises reads, writes, timeout, IRQ and reset; a
//             NUM_FULL=4 instance covers an unmapped full-slot read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tqv_peri_fabric;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic [1:0]    wn = 2'b11, rn = 2'b11;
    logic          cmpl = 1'b0;
    logic [31:0]   dout;
    logic          drdy;
    logic [23:0]   swn, srn;
    logic [383:0]  sdata = '0;
    logic [11:0]   srdy = '1;
    logic [7:0]    bw;
    logic [63:0]   bdata = '0;
    logic [11:0]   sirq = '0, iout;

    logic [1:0]    wn2 = 2'b11, rn2 = 2'b11;
    logic          cmpl2 = 1'b0;
    logic [31:0]   dout2;
    logic          drdy2;
    logic [7:0]    swn2, srn2;
    logic [127:0]  sdata2 = '0;
    logic [3:0]    srdy2 = '1;
    logic [7:0]    bw2;
    logic [63:0]   bdata2 = '0;
    logic [3:0]    sirq2 = '0, iout2;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    int          obs_lat;
    logic [31:0] obs_data, obs_held;
    logic [1:0]  obs_hold_strb, obs_wait_strb;
    logic        obs_ready_after, obs_wr_ready;
    logic [23:0] obs_req_srn, obs_swn;
    logic [7:0]  obs_bw, obs_bw_after;

    always #5 clk = ~clk;

    tqv_peri_fabric dut (
        .clk(clk), .rst_n(rst_n), .addr_in(addr), .data_in(wdata),
        .data_write_n(wn), .data_read_n(rn), .data_read_complete(cmpl),
        .data_out(dout), .data_ready(drdy), .slot_write_n(swn), .slot_read_n(srn),
        .slot_data(sdata), .slot_ready(srdy), .byte_write(bw), .byte_data(bdata),
        .slot_irq(sirq), .irq_out(iout)
    );

    tqv_peri_fabric #(.NUM_FULL(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .addr_in(addr), .data_in(wdata),
        .data_write_n(wn2), .data_read_n(rn2), .data_read_complete(cmpl2),
        .data_out(dout2), .data_ready(drdy2), .slot_write_n(swn2), .slot_read_n(srn2),
        .slot_data(sdata2), .slot_ready(srdy2), .byte_write(bw2), .byte_data(bdata2),
        .slot_irq(sirq2), .irq_out(iout2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one read, records what the DUT did; the calling test compares.
    // slot > 0 names the external slot whose ready is delayed by 'delay' cycles.
    task automatic do_read(input logic [10:0] a, input logic [31:0] e, input int slot, input int delay);
        addr = a;
        rn = 2'b10;
        exp_q.push_back(e);
        if (slot > 0) srdy[slot] = (delay == 0);
        #1;
        obs_req_srn   = srn;
        obs_lat       = 0;
        obs_wait_strb = 2'b11;
        while (drdy !== 1'b1 && obs_lat < 200) begin
            tick();
            obs_lat++;
            if (slot > 0 && obs_lat == 1 && drdy !== 1'b1) obs_wait_strb = srn[2*slot +: 2];
            if (slot > 0 && obs_lat >= delay) srdy[slot] = 1'b1;
        end
        obs_data      = dout;
        obs_hold_strb = (slot > 0) ? srn[2*slot +: 2] : 2'b11;
        rn = 2'b11;
        tick();
        obs_ready_after = drdy;
        obs_held        = dout;
        cmpl = 1'b1;
        tick();
        cmpl = 1'b0;
        if (slot > 0) srdy[slot] = 1'b1;
    endtask

    task automatic do_write(input logic [10:0] a, input logic [31:0] d, input logic [1:0] w);
        addr  = a;
        wdata = d;
        wn    = w;
        #1;
        obs_wr_ready = drdy;
        obs_swn      = swn;
        obs_bw       = bw;
        tick();
        wn = 2'b11;
        #1;
        obs_bw_after = bw;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sirq  = '1;
        tick(); tick();
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want %h", dout, 32'h0); end
        checks++; if (drdy !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b want 0", drdy); end
        checks++; if (iout !== 12'h0) begin errors++; $display("FAIL reset_irq_out: got %h want 000", iout); end
        checks++; if (srn !== {24{1'b1}}) begin errors++; $display("FAIL reset_slot_read_n: got %h want ffffff", srn); end
        rst_n = 1'b1;
        sirq  = '0;
        tick();
    endtask

    task automatic test_full_read();
        logic [31:0] e;
        do_read(11'h0C0, 32'h1234_5678, 3, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL rd3_data: got %h want %h", obs_data, e); end
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL rd3_latency: got %0d want 1", obs_lat); end
        checks++; if (obs_hold_strb !== 2'b11) begin errors++; $display("FAIL rd3_hold_strobe: got %b want 11", obs_hold_strb); end
        checks++; if (obs_ready_after !== 1'b0) begin errors++; $display("FAIL rd3_ready_pulse: got %b want 0", obs_ready_after); end
        checks++; if (obs_held !== e) begin errors++; $display("FAIL rd3_held: got %h want %h", obs_held, e); end
    endtask

    task automatic test_wait_read();
        logic [31:0] e;
        do_read(11'h140, 32'hCAFE_0005, 5, 5);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL rd5_data: got %h want %h", obs_data, e); end
        checks++; if (obs_lat !== 6) begin errors++; $display("FAIL rd5_latency: got %0d want 6", obs_lat); end
        checks++; if (obs_wait_strb !== 2'b10) begin errors++; $display("FAIL rd5_wait_strobe: got %b want 10", obs_wait_strb); end
        do_read(11'h008, 32'h0, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL rd5_no_timeout: got %h want %h", obs_data, e); end
    endtask

    task automatic test_timeout();
        logic [31:0] e;
        do_read(11'h180, 32'hDEAD_BEEF, 6, 100000);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL to_data: got %h want %h", obs_data, e); end
        checks++; if (obs_lat !== 65) begin errors++; $display("FAIL to_latency: got %0d want 65", obs_lat); end
        do_read(11'h008, 32'h61, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL to_reg: got %h want %h", obs_data, e); end
        do_write(11'h008, 32'h1, 2'b10);
        do_read(11'h008, 32'h0, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL to_clear: got %h want %h", obs_data, e); end
    endtask

    task automatic test_byte();
        logic [31:0] e;
        logic [23:0] ew;
        do_read(11'h420, 32'h0000_00A5, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL byte_rd: got %h want %h", obs_data, e); end
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL byte_latency: got %0d want 1", obs_lat); end
        do_write(11'h420, 32'h5A, 2'b00);
        checks++; if (obs_bw !== 8'h04) begin errors++; $display("FAIL byte_wr_strobe: got %h want 04", obs_bw); end
        checks++; if (obs_bw_after !== 8'h00) begin errors++; $display("FAIL byte_wr_pulse: got %h want 00", obs_bw_after); end
        checks++; if (obs_wr_ready !== 1'b1) begin errors++; $display("FAIL byte_wr_ready: got %b want 1", obs_wr_ready); end
        checks++; if (obs_swn !== {24{1'b1}}) begin errors++; $display("FAIL byte_wr_full_idle: got %h want ffffff", obs_swn); end
        ew = {24{1'b1}};
        ew[7:6] = 2'b01;
        do_write(11'h0C0, 32'h1111, 2'b01);
        checks++; if (obs_swn !== ew) begin errors++; $display("FAIL full_wr_strobe: got %h want %h", obs_swn, ew); end
    endtask

    task automatic test_irq();
        logic [31:0] e;
        do_write(11'h000, 32'h0011, 2'b10);
        sirq = 12'h030;
        #1;
        checks++; if (iout !== 12'h000) begin errors++; $display("FAIL irq_latency: got %h want 000", iout); end
        tick();
        checks++; if (iout !== 12'h010) begin errors++; $display("FAIL irq_out: got %h want 010", iout); end
        do_read(11'h004, 32'h30, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL irq_status: got %h want %h", obs_data, e); end
        do_read(11'h000, 32'h10, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL irq_en_rd: got %h want %h", obs_data, e); end
    endtask

    task automatic test_unmapped();
        logic [31:0] e;
        do_read(11'h3C0, 32'h0, 0, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL unm15_data: got %h want %h", obs_data, e); end
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL unm15_latency: got %0d want 1", obs_lat); end
        checks++; if (obs_req_srn !== {24{1'b1}}) begin errors++; $display("FAIL unm15_strobe: got %h want ffffff", obs_req_srn); end
        // Small instance: slot 6 does not exist.
        addr = 11'h180;
        rn2  = 2'b10;
        exp_q.push_back(32'h0);
        #1;
        checks++; if (srn2 !== 8'hFF) begin errors++; $display("FAIL unm4_strobe: got %h want ff", srn2); end
        tick();
        e = exp_q.pop_front();
        checks++; if (drdy2 !== 1'b1) begin errors++; $display("FAIL unm4_ready: got %b want 1", drdy2); end
        checks++; if (dout2 !== e) begin errors++; $display("FAIL unm4_data: got %h want %h", dout2, e); end
        rn2   = 2'b11;
        cmpl2 = 1'b1;
        tick();
        cmpl2 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] e;
        int lat;
        addr = 11'h0C0;
        rn   = 2'b10;
        exp_q.push_back(32'h1234_5678);
        lat = 0;
        while (drdy !== 1'b1 && lat < 10) begin tick(); lat++; end
        e = exp_q.pop_front();
        checks++; if (dout !== e) begin errors++; $display("FAIL b2b_first: got %h want %h", dout, e); end
        sdata[32*3 +: 32] = 32'h8765_4321;
        exp_q.push_back(32'h8765_4321);
        cmpl = 1'b1;
        tick();
        cmpl = 1'b0;
        checks++; if (drdy !== 1'b0) begin errors++; $display("FAIL b2b_gap: got %b want 0", drdy); end
        tick();
        e = exp_q.pop_front();
        checks++; if (drdy !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b want 1", drdy); end
        checks++; if (dout !== e) begin errors++; $display("FAIL b2b_second: got %h want %h", dout, e); end
        rn   = 2'b11;
        cmpl = 1'b1;
        tick();
        cmpl = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        addr    = 11'h180;
        srdy[6] = 1'b0;
        rn      = 2'b10;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rstmid_data: got %h want 0", dout); end
        checks++; if (drdy !== 1'b0) begin errors++; $display("FAIL rstmid_ready: got %b want 0", drdy); end
        rst_n = 1'b1;
        rn    = 2'b11;
        tick();
        do_read(11'h180, 32'h6666_6666, 6, 0);
        e = exp_q.pop_front();
        checks++; if (obs_data !== e) begin errors++; $display("FAIL rstmid_reissue: got %h want %h", obs_data, e); end
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL rstmid_latency: got %0d want 1", obs_lat); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        sdata[32*3 +: 32]  = 32'h1234_5678;
        sdata[32*5 +: 32]  = 32'hCAFE_0005;
        sdata[32*6 +: 32]  = 32'h6666_6666;
        bdata[8*2 +: 8]    = 8'hA5;
        test_reset();
        test_full_read();
        test_wait_read();
        test_timeout();
        test_byte();
        test_irq();
        test_unmapped();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
